// File: rtl/amo_arbiter_pkg.sv
// Shared types for the AMO port arbiter: AMO opcodes, the dcache AMO request and
// response structs, and the arbiter state encoding.
package amo_arbiter_pkg;

    localparam int unsigned AMO_XLEN = 64;

    typedef enum logic [3:0] {
        AMO_NONE = 4'b0000,
        AMO_LR   = 4'b0001,
        AMO_SC   = 4'b0010,
        AMO_SWAP = 4'b0011,
        AMO_ADD  = 4'b0100,
        AMO_AND  = 4'b0101,
        AMO_OR   = 4'b0110,
        AMO_XOR  = 4'b0111,
        AMO_MAX  = 4'b1000,
        AMO_MAXU = 4'b1001,
        AMO_MIN  = 4'b1010,
        AMO_MINU = 4'b1011,
        AMO_CAS1 = 4'b1100,
        AMO_CAS2 = 4'b1101
    } amo_t;

    typedef struct packed {
        logic                req;
        amo_t                amo_op;
        logic [1:0]          size;
        logic [AMO_XLEN-1:0] operand_a;
        logic [AMO_XLEN-1:0] operand_b;
    } amo_req_t;

    typedef struct packed {
        logic                ack;
        logic [AMO_XLEN-1:0] result;
    } amo_resp_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        REQ
    } amo_arb_state_e;

    // Index width that stays legal (>=1 bit) even for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/amo_arbiter_rr_pick.sv
// Combinational round-robin selector: picks the first valid index at or after
// the pointer, wrapping around, and returns it both one-hot and encoded.
module amo_arbiter_rr_pick
    import amo_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned IDXW    = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDXW-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDXW-1:0]    idx,
    output logic               any_valid
);

    localparam logic [IDXW:0] N_W = (IDXW+1)'(NUM_REQ);

    logic [IDXW:0]   sum  [NUM_REQ];
    logic [IDXW-1:0] cand [NUM_REQ];

    // cand[k] is the requester k positions after the pointer; ptr < NUM_REQ
    // keeps the sum below 2*NUM_REQ, so one conditional subtract wraps it.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
        assign sum[gi]  = {1'b0, ptr} + (IDXW+1)'(gi);
        assign cand[gi] = (sum[gi] >= N_W) ? IDXW'(sum[gi] - N_W) : sum[gi][IDXW-1:0];
    end

    always_comb begin
        idx       = '0;
        any_valid = 1'b0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (valid[cand[k]]) begin
                idx       = cand[k];
                any_valid = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
        assign grant[gi] = any_valid && (idx == IDXW'(gi));
    end

endmodule

// File: rtl/amo_arbiter.sv
// Shares the dcache AMO port between NUM_REQ requesters with round-robin grant,
// store-buffer drain gating and a single outstanding AMO at a time.
module amo_arbiter
    import amo_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned XLEN    = 64,
    parameter int unsigned PLEN    = 56
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    flush_i,
    input  logic [NUM_REQ-1:0]      req_valid_i,
    output logic [NUM_REQ-1:0]      req_ready_o,
    input  logic [NUM_REQ*4-1:0]    req_op_i,
    input  logic [NUM_REQ*PLEN-1:0] req_addr_i,
    input  logic [NUM_REQ*XLEN-1:0] req_data_i,
    input  logic [NUM_REQ*2-1:0]    req_size_i,
    output logic [NUM_REQ-1:0]      resp_valid_o,
    output logic [XLEN-1:0]         resp_result_o,
    input  logic                    no_st_pending_i,
    output amo_req_t                amo_req_o,
    input  amo_resp_t               amo_resp_i
);

    localparam int unsigned     IDXW     = idx_width(NUM_REQ);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REQ - 1);

    amo_t            op_arr   [NUM_REQ];
    logic [PLEN-1:0] addr_arr [NUM_REQ];
    logic [XLEN-1:0] data_arr [NUM_REQ];
    logic [1:0]      size_arr [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign op_arr[gi]   = amo_t'(req_op_i[gi*4 +: 4]);
        assign addr_arr[gi] = req_addr_i[gi*PLEN +: PLEN];
        assign data_arr[gi] = req_data_i[gi*XLEN +: XLEN];
        assign size_arr[gi] = req_size_i[gi*2 +: 2];
    end

    amo_arb_state_e  state_reg;
    logic [IDXW-1:0] ptr_reg;
    logic [IDXW-1:0] owner_reg;
    amo_t            op_reg;
    logic [PLEN-1:0] addr_reg;
    logic [XLEN-1:0] data_reg;
    logic [1:0]      size_reg;
    logic            drop_reg;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDXW-1:0]    pick_idx;
    logic               pick_any;

    amo_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .valid     (req_valid_i),
        .ptr       (ptr_reg),
        .grant     (pick_grant),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    logic grant_now;
    logic none_resp;
    logic ack_resp;
    logic resp_fire;

    assign grant_now = (state_reg == IDLE) && pick_any && !flush_i;
    // An AMO_NONE never reaches the cache; it is answered with zero while draining.
    assign none_resp = (state_reg == DRAIN) && (op_reg == AMO_NONE) && !flush_i;
    // A flush on the ack cycle itself suppresses the response just like drop_reg.
    assign ack_resp  = (state_reg == REQ) && amo_resp_i.ack && !drop_reg && !flush_i;
    assign resp_fire = none_resp || ack_resp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            owner_reg <= '0;
            op_reg    <= AMO_NONE;
            addr_reg  <= '0;
            data_reg  <= '0;
            size_reg  <= '0;
            drop_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_now) begin
                        owner_reg <= pick_idx;
                        op_reg    <= op_arr[pick_idx];
                        addr_reg  <= addr_arr[pick_idx];
                        data_reg  <= data_arr[pick_idx];
                        size_reg  <= size_arr[pick_idx];
                        ptr_reg   <= (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
                        state_reg <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (flush_i || op_reg == AMO_NONE) begin
                        state_reg <= IDLE;
                    end else if (no_st_pending_i) begin
                        drop_reg  <= 1'b0;
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    // The cache cannot cancel, so a flush only marks the result as unwanted.
                    if (flush_i) begin
                        drop_reg <= 1'b1;
                    end
                    if (amo_resp_i.ack) begin
                        drop_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready_o = grant_now ? pick_grant : '0;
    end

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_resp
        assign resp_valid_o[gi] = resp_fire && (owner_reg == IDXW'(gi));
    end

    assign resp_result_o = ack_resp ? XLEN'(amo_resp_i.result) : '0;

    always_comb begin
        amo_req_o        = '0;
        amo_req_o.amo_op = AMO_NONE;
        if (state_reg == REQ) begin
            amo_req_o.req       = 1'b1;
            amo_req_o.amo_op    = op_reg;
            amo_req_o.size      = size_reg;
            amo_req_o.operand_a = AMO_XLEN'(addr_reg);
            amo_req_o.operand_b = AMO_XLEN'(data_reg);
        end
    end

`ifndef SYNTHESIS
    ack_only_in_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
        amo_resp_i.ack |-> (state_reg == REQ));
`endif

endmodule

// File: tb/tb_amo_arbiter.sv
// Randomized bench for amo_arbiter: per-requester AMO queues, a transaction-level
// reference (round-robin owner, drain/flush rules, cache responder) checked every cycle.
module tb_amo_arbiter;
    import amo_arbiter_pkg::*;

    localparam int NR = 2;
    localparam int XL = 64;
    localparam int PL = 56;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              flush_i;
    logic [NR-1:0]     req_valid_i;
    logic [NR-1:0]     req_ready_o;
    logic [NR*4-1:0]   req_op_i;
    logic [NR*PL-1:0]  req_addr_i;
    logic [NR*XL-1:0]  req_data_i;
    logic [NR*2-1:0]   req_size_i;
    logic [NR-1:0]     resp_valid_o;
    logic [XL-1:0]     resp_result_o;
    logic              no_st_pending_i;
    amo_req_t          amo_req_o;
    amo_resp_t         amo_resp_i;

    amo_arbiter #(.NUM_REQ(NR), .XLEN(XL), .PLEN(PL)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .flush_i         (flush_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_op_i        (req_op_i),
        .req_addr_i      (req_addr_i),
        .req_data_i      (req_data_i),
        .req_size_i      (req_size_i),
        .resp_valid_o    (resp_valid_o),
        .resp_result_o   (resp_result_o),
        .no_st_pending_i (no_st_pending_i),
        .amo_req_o       (amo_req_o),
        .amo_resp_i      (amo_resp_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0]    op;
        logic [PL-1:0] addr;
        logic [XL-1:0] data;
        logic [1:0]    size;
    } txn_t;

    txn_t pend [NR][$];

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Transaction phases of the reference: 0 free, 1 accepted and waiting for the
    // store buffer, 2 handed to the cache.
    int        phase;
    int        rr_next;
    int        owner;
    txn_t      cur;
    bit        dropped;
    int        ack_wait;
    int        ack_delay;
    logic [XL-1:0] ack_result;

    int p_new, p_flush, p_nsp, max_delay;

    function automatic txn_t new_txn();
        txn_t t;
        logic [63:0] r64;
        r64    = {$urandom, $urandom};
        t.addr = r64[PL-1:0];
        t.data = {$urandom, $urandom};
        t.op   = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 13));
        t.size = 2'($urandom_range(2, 3));
        return t;
    endfunction

    task automatic drive_idle_inputs();
        req_valid_i     = '0;
        req_op_i        = '0;
        req_addr_i      = '0;
        req_data_i      = '0;
        req_size_i      = '0;
        flush_i         = 1'b0;
        no_st_pending_i = 1'b0;
        amo_resp_i      = '0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, 128'(req_ready_o), 128'd0);
        check({tag, "_resp"}, 128'(resp_valid_o), 128'd0);
        check({tag, "_req"}, 128'(amo_req_o.req), 128'd0);
        check({tag, "_op"}, 128'(amo_req_o.amo_op), 128'd0);
        check({tag, "_result"}, 128'(resp_result_o), 128'd0);
    endtask

    task automatic model_reset();
        phase   = 0;
        rr_next = 0;
        owner   = 0;
        dropped = 0;
    endtask

    initial begin
        int       g;
        bit       did_reset;
        int       reset_hold;
        logic [NR-1:0] v;
        logic [NR-1:0] exp_ready, exp_resp;
        logic [XL-1:0] exp_result;
        bit       exp_req;

        rst_ni = 1'b0;
        drive_idle_inputs();
        model_reset();
        did_reset  = 0;
        reset_hold = 0;
        repeat (3) @(negedge clk_i);
        #1;
        check_all_zero("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc < 400) begin
                p_new = 100; p_flush = 0; p_nsp = 100; max_delay = 0;
            end else if (cyc < 1200) begin
                p_new = 50; p_flush = 0; p_nsp = 40; max_delay = 4;
            end else begin
                p_new = 40; p_flush = 8; p_nsp = 50; max_delay = 5;
            end

            if (cyc > 0) @(negedge clk_i);

            // Asynchronous reset while an AMO sits at the cache.
            if (!did_reset && cyc > 1500 && phase == 2) begin
                did_reset  = 1;
                reset_hold = 2;
            end
            if (reset_hold > 0) begin
                rst_ni = 1'b0;
                drive_idle_inputs();
                #1;
                check_all_zero("midreset");
                model_reset();
                reset_hold--;
                continue;
            end
            rst_ni = 1'b1;

            for (int i = 0; i < NR; i++) begin
                if (pend[i].size() == 0 && $urandom_range(0, 99) < p_new)
                    pend[i].push_back(new_txn());
                v[i] = (pend[i].size() != 0);
                if (v[i]) begin
                    req_op_i[i*4 +: 4]    = pend[i][0].op;
                    req_addr_i[i*PL +: PL] = pend[i][0].addr;
                    req_data_i[i*XL +: XL] = pend[i][0].data;
                    req_size_i[i*2 +: 2]  = pend[i][0].size;
                end else begin
                    req_op_i[i*4 +: 4]    = '0;
                    req_addr_i[i*PL +: PL] = '0;
                    req_data_i[i*XL +: XL] = '0;
                    req_size_i[i*2 +: 2]  = '0;
                end
            end
            req_valid_i     = v;
            flush_i         = ($urandom_range(0, 99) < p_flush);
            no_st_pending_i = ($urandom_range(0, 99) < p_nsp);
            ack_result      = {$urandom, $urandom};
            amo_resp_i.ack    = (phase == 2) && (ack_wait >= ack_delay);
            amo_resp_i.result = ack_result;
            #1;

            exp_ready  = '0;
            exp_resp   = '0;
            exp_result = '0;
            exp_req    = 0;
            g          = -1;
            if (phase == 0 && !flush_i) begin
                for (int k = 0; k < NR; k++) begin
                    if (g < 0 && v[(rr_next + k) % NR]) g = (rr_next + k) % NR;
                end
                if (g >= 0) exp_ready[g] = 1'b1;
            end else if (phase == 1) begin
                if (cur.op == 4'd0 && !flush_i) exp_resp[owner] = 1'b1;
            end else if (phase == 2) begin
                exp_req = 1;
                if (amo_resp_i.ack && !dropped && !flush_i) begin
                    exp_resp[owner] = 1'b1;
                    exp_result      = ack_result;
                end
            end

            check("ready", 128'(req_ready_o), 128'(exp_ready));
            check("resp_valid", 128'(resp_valid_o), 128'(exp_resp));
            check("cache_req", 128'(amo_req_o.req), 128'(exp_req));
            if (exp_req) begin
                check("cache_op", 128'(amo_req_o.amo_op), 128'(cur.op));
                check("cache_size", 128'(amo_req_o.size), 128'(cur.size));
                check("operand_a", 128'(amo_req_o.operand_a), 128'(cur.addr));
                check("operand_b", 128'(amo_req_o.operand_b), 128'(cur.data));
            end else begin
                check("cache_op_idle", 128'(amo_req_o.amo_op), 128'd0);
            end
            if (exp_resp != '0) check("result", 128'(resp_result_o), 128'(exp_result));

            case (phase)
                0: if (g >= 0) begin
                    cur     = pend[g].pop_front();
                    owner   = g;
                    rr_next = (g + 1) % NR;
                    phase   = 1;
                end
                1: begin
                    if (flush_i) begin
                        $display("txn owner=%0d op=%0d flushed before issue", owner, cur.op);
                        phase = 0;
                    end else if (cur.op == 4'd0) begin
                        $display("txn owner=%0d op=none answered with zero", owner);
                        phase = 0;
                    end else if (no_st_pending_i) begin
                        phase     = 2;
                        dropped   = 0;
                        ack_wait  = 0;
                        ack_delay = $urandom_range(0, max_delay);
                    end
                end
                default: begin
                    if (flush_i) dropped = 1;
                    if (amo_resp_i.ack) begin
                        $display("txn owner=%0d op=%0d addr=%0h result=%0h %s", owner, cur.op,
                                 cur.addr, ack_result, dropped ? "dropped" : "returned");
                        phase = 0;
                    end else begin
                        ack_wait++;
                    end
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
